// File: rtl/addsub_serial_16_bit.sv
// Nibble-serial add/subtract engine: one 4-bit nibble per clock through a ripple
// nibble adder with a registered carry; widened sdout/cbout plus signed overflow.
module addsub_serial_16_bit #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*N_NIB-1:0]   a,
  input  logic [4*N_NIB-1:0]   b,
  input  logic                 en,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_NIB-1:0]   sdout,
  output logic                 cbout,
  output logic                 ovf
);

  localparam int W  = 4 * N_NIB;
  localparam int IW = $clog2(N_NIB);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_en;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_sdout;
  logic            r_cbout;
  logic            r_ovf;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_sum;
  logic [3:0]      w_low;
  logic            w_ovf;
  logic            w_last;
  logic            w_accept;

  always_comb begin
    w_a_nib = r_a[4*r_idx +: 4];
    w_b_nib = r_b[4*r_idx +: 4] ^ {4{r_en}};
    w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, r_carry};
    // Carry into the nibble's MSB comes from the low three bits alone.
    w_low   = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b0, r_carry};
    w_ovf   = w_low[3] ^ w_sum[4];
    w_last  = (r_idx == IW'(N_NIB - 1));
    w_accept = start && (r_state != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_en    <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sdout <= '0;
      r_cbout <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= S_RUN;
            r_a     <= a;
            r_b     <= b;
            r_en    <= en;
            r_carry <= en;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_sdout <= '0;
            r_cbout <= 1'b0;
            r_ovf   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sdout[4*r_idx +: 4] <= w_sum[3:0];
          r_carry <= w_sum[4];
          if (w_last) begin
            r_state <= S_DONE;
            r_cbout <= w_sum[4];
            r_ovf   <= w_ovf;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sdout = r_sdout;
  assign cbout = r_cbout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_addsub_serial_16_bit.sv
// Bench for addsub_serial_16_bit: directed vector table, corner sequences, and
// random operations against an integer-arithmetic reference model.
module tb_addsub_serial_16_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        en;
  logic        busy;
  logic        done;
  logic [15:0] sdout;
  logic        cbout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  addsub_serial_16_bit #(.N_NIB(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .en(en),
    .busy(busy), .done(done), .sdout(sdout), .cbout(cbout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        ven;
    logic [15:0] esd;
    logic        ecb;
    logic        eovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on whole operands.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic men,
                       output logic [15:0] rsd, output logic rcb, output logic rovf);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ur = men ? (ua - ub) : (ua + ub);
    sr = men ? (sa - sb) : (sa + sb);
    rsd  = ur[15:0];
    rcb  = men ? (ua >= ub) : (ur > 65535);
    rovf = (sr > 32767) || (sr < -32768);
  endtask

  // Starts an op from idle, checks latency, pulse width and the result.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ten,
                        input logic [15:0] esd, input logic ecb, input logic eovf,
                        input string nm);
    int lat;
    a = ta; b = tb; en = ten; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); en = 1'($urandom);
    check({nm, " busy_after_accept"}, 32'(busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    check({nm, " latency"}, 32'(lat), 32'd4);
    check({nm, " busy_in_done"}, 32'(busy), 32'd0);
    check({nm, " sdout"}, 32'(sdout), 32'(esd));
    check({nm, " cbout"}, 32'(cbout), 32'(ecb));
    check({nm, " ovf"}, 32'(ovf), 32'(eovf));
    @(posedge clk); #1;
    check({nm, " done_width"}, 32'(done), 32'd0);
    check({nm, " sdout_hold"}, 32'(sdout), 32'(esd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    logic [15:0] msd;
    logic        mcb, movf;
    int          lat, npulse;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sdout", 32'(sdout), 32'd0);
    check("reset cbout", 32'(cbout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].ven, vecs[i].esd, vecs[i].ecb,
             vecs[i].eovf, $sformatf("vec%0d", i));

    // start during RUN is ignored; start in DONE is accepted back-to-back
    a = 16'h1111; b = 16'h2222; en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ignore busy", 32'(busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    check("busy_ignore latency", 32'(lat), 32'd2);
    check("busy_ignore sdout", 32'(sdout), 32'h3333);
    check("busy_ignore cbout", 32'(cbout), 32'd0);
    a = 16'h0101; b = 16'h0202; en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done_fall", 32'(done), 32'd0);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      check("b2b busy_no_gap", 32'(busy | done), 32'd1);
      if (done) lat = i;
    end
    check("b2b latency", 32'(lat), 32'd4);
    check("b2b sdout", 32'(sdout), 32'h0303);
    @(posedge clk); #1;

    // reset mid-RUN aborts without a done pulse
    a = 16'h1234; b = 16'h1111; en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sdout", 32'(sdout), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort cbout", 32'(cbout), 32'd0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    check("abort no_done", 32'(npulse), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_abort");

    // start with rst on the same edge: reset wins
    a = 16'h0003; b = 16'h0004; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    check("rst_prio busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      logic        ren;
      ra = 16'($urandom);
      rb = 16'($urandom);
      ren = 1'($urandom);
      if (n < 4) rb = (n % 2 == 0) ? ra : 16'h8000;
      model(ra, rb, ren, msd, mcb, movf);
      run_op(ra, rb, ren, msd, mcb, movf, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
